// File: rtl/dmem_lsu_ctrl_if.sv
// Request/response bus of the RV32 data memory load/store unit.
// The master (MEM stage) issues requests; the slave (dmem_lsu_ctrl) returns
// exactly one response per accepted request.
interface dmem_lsu_ctrl_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [2:0]        req_funct3;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_funct3,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_funct3,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_lsu_ctrl.sv
// Byte-addressable RV32 data memory with a load/store unit front end.
// Synchronous-read word memory, fully pipelined requests with a fixed
// READ_LAT response latency, sub-word load extraction, byte-enable stores,
// error reporting and an optional zero-fill sweep after reset.
// Optional macro DMEM_PERF_CNT_EN adds saturating load/store/error counters.
module dmem_lsu_ctrl #(
    parameter int NUM_WORDS   = 1024,
    parameter int ADDR_W      = 12,
    parameter int READ_LAT    = 1,
    parameter int RESET_CLEAR = 1
) (
    input  logic           clk,
    input  logic           n_rst,
    dmem_lsu_ctrl_if.slave bus,
    output logic           busy
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0]    perf_loads,
    output logic [31:0]    perf_stores,
    output logic [31:0]    perf_errs
`endif
);
    localparam int IDX_W = $clog2(NUM_WORDS);

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;
    localparam state_t RST_STATE = (RESET_CLEAR != 0) ? ST_CLEAR : ST_RUN;

    // Everything a response needs, carried alongside the valid bit
    typedef struct packed {
        logic [31:0] word;
        logic [1:0]  off;
        logic [2:0]  f3;
        logic        we;
        logic        err;
    } stage_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   clr_idx_q, clr_idx_d;
    logic               clr_we;

    logic               accept;
    logic [1:0]         off;
    logic [IDX_W-1:0]   widx;
    logic [2:0]         f3;
    logic               illegal, misalign, oor, err;
    logic [3:0]         be;
    logic [31:0]        wlane;

    logic [31:0]        mem [NUM_WORDS];
    logic [READ_LAT-1:0] vld_q;
    stage_t             stg_q [READ_LAT];
    stage_t             last;

    // Shift the word down to the addressed byte/half and extend per funct3
    function automatic logic [31:0] extract(input logic [31:0] word,
                                            input logic [1:0]  off_a,
                                            input logic [2:0]  f3_a);
        logic [31:0]        sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        logic signed [31:0] r;
        sh  = word >> {off_a, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (f3_a)
            3'd0:    r = sb;
            3'd1:    r = shw;
            3'd4:    r = {24'd0, sh[7:0]};
            3'd5:    r = {16'd0, sh[15:0]};
            default: r = sh;
        endcase
        return r;
    endfunction

    // FSM state and sweep index register
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= RST_STATE;
            clr_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
        end
    end

    // Next state: sweep one word per cycle, then run forever
    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == IDX_W'(NUM_WORDS - 1)) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.req_ready = (state_q == ST_RUN);
        clr_we        = (state_q == ST_CLEAR);
    end

    // Request decode, error classification and store lane steering
    always_comb begin
        accept   = bus.req_valid & bus.req_ready;
        off      = bus.req_addr[1:0];
        widx     = bus.req_addr[IDX_W+1:2];
        f3       = bus.req_funct3;
        if (bus.req_we) illegal = (f3 > 3'd2);
        else            illegal = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        misalign = ((f3[1:0] == 2'd1) && off[0]) || ((f3[1:0] == 2'd2) && (off != 2'd0));
        oor      = (bus.req_addr >> (IDX_W + 2)) != '0;
        err      = illegal | misalign | oor;
        case (f3[1:0])
            2'd0: begin
                be    = 4'b0001 << off;
                wlane = {4{bus.req_wdata[7:0]}};
            end
            2'd1: begin
                be    = 4'b0011 << off;
                wlane = {2{bus.req_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.req_wdata;
            end
        endcase
    end

    // Memory write port: the sweep owns it while clearing, stores afterwards
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx_q] <= '0;
        end else if (accept && bus.req_we && !err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[widx][8*b +: 8] <= wlane[8*b +: 8];
        end
    end

    // Response datapath: stage 0 samples the word, later stages just delay
    always_ff @(posedge clk) begin
        stg_q[0] <= '{word: mem[widx], off: off, f3: f3, we: bus.req_we, err: err};
        for (int s = 1; s < READ_LAT; s++) stg_q[s] <= stg_q[s-1];
    end

    // Response valid pipeline; reset drops in-flight responses
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= accept;
            for (int s = 1; s < READ_LAT; s++) vld_q[s] <= vld_q[s-1];
        end
    end

    // Response outputs, forced to zero outside a valid strobe
    always_comb begin
        last          = stg_q[READ_LAT-1];
        bus.rsp_valid = vld_q[READ_LAT-1];
        bus.rsp_err   = vld_q[READ_LAT-1] & last.err;
        bus.rsp_rdata = (vld_q[READ_LAT-1] && !last.err && !last.we)
                        ? extract(last.word, last.off, last.f3) : '0;
        busy          = (state_q == ST_CLEAR) | (|vld_q);
    end

`ifdef DMEM_PERF_CNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Saturating per-class request counters
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            perf_loads  <= '0;
            perf_stores <= '0;
            perf_errs   <= '0;
        end else if (accept) begin
            if (err)             perf_errs   <= sat_inc(perf_errs);
            else if (bus.req_we) perf_stores <= sat_inc(perf_stores);
            else                 perf_loads  <= sat_inc(perf_loads);
        end
    end
`endif
endmodule

// File: tb/tb_dmem_lsu_ctrl.sv
// Scoreboard bench for dmem_lsu_ctrl: directed and random requests, with
// expectations from a byte-array memory model checked by a separate monitor.
module tb_dmem_lsu_ctrl;
    localparam int NW = 1024;
    localparam int AW = 13;
    localparam int RL = 3;

    typedef struct {
        logic [31:0] rd;
        logic        er;
        int          cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    logic busy;
    int   cyc   = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    exp_t sbq[$];
    logic [7:0] mb [NW*4];

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] perf_loads, perf_stores, perf_errs;
`endif

    dmem_lsu_ctrl_if #(.ADDR_W(AW)) bus ();

    dmem_lsu_ctrl #(
        .NUM_WORDS(NW), .ADDR_W(AW), .READ_LAT(RL), .RESET_CLEAR(1)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .bus(bus),
        .busy(busy)
`ifdef DMEM_PERF_CNT_EN
        , .perf_loads(perf_loads), .perf_stores(perf_stores), .perf_errs(perf_errs)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        foreach (mb[i]) mb[i] = 8'h00;
    endfunction

    // Little-endian byte memory; legality from access size and funct3
    function automatic void model(input logic we, input int addr, input logic [31:0] wd,
                                  input logic [2:0] f3, output logic [31:0] rd,
                                  output logic er);
        int          n;
        logic [31:0] v;
        bit          legal;
        legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        n  = 1 << f3[1:0];
        rd = 32'd0;
        er = 1'b0;
        if (!legal || (addr % n) != 0 || addr >= NW*4) begin
            er = 1'b1;
            return;
        end
        if (we) begin
            for (int i = 0; i < n; i++) mb[addr+i] = wd[8*i +: 8];
            return;
        end
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(mb[addr+i]) << (8*i));
        case (f3)
            3'd0:    rd = {{24{v[7]}}, v[7:0]};
            3'd1:    rd = {{16{v[15]}}, v[15:0]};
            default: rd = v;
        endcase
    endfunction

    // Present one request (called at a falling edge), wait for acceptance
    task automatic issue(input logic we, input int addr, input logic [31:0] wd,
                         input logic [2:0] f3, input bit use_exp,
                         input logic [31:0] exp_rd, input logic exp_er);
        int          w;
        logic [31:0] m_rd;
        logic        m_er;
        exp_t        e;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_addr   = AW'(addr);
        bus.req_wdata  = wd;
        bus.req_funct3 = f3;
        w = 0;
        while (!bus.req_ready && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (!bus.req_ready) begin
            chk("accept_timeout", 32'(bus.req_ready), 32'd1);
            bus.req_valid = 1'b0;
            return;
        end
        model(we, addr, wd, f3, m_rd, m_er);
        e.rd  = use_exp ? exp_rd : m_rd;
        e.er  = use_exp ? exp_er : m_er;
        e.cyc = cyc + RL;
        sbq.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        #1;
        while (!bus.req_ready && n < 5000) begin
            n++;
            @(negedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("drain_left", 32'(sbq.size()), 32'd0);
    endtask

    // Monitor: pop the oldest expectation whenever a response appears
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!n_rst) begin
            chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        end else if (bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", bus.rsp_rdata, e.rd);
                chk("rsp_err", 32'(bus.rsp_err), 32'(e.er));
                chk("rsp_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else begin
            chk("idle_zero", {bus.rsp_rdata[30:0], bus.rsp_err}, 32'd0);
        end
    end

    initial begin
        int n;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_funct3 = '0;
        model_clear();

        // Reset values and clear sweep length
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_rdata", bus.rsp_rdata, 32'd0);
        chk("rst_err", 32'(bus.rsp_err), 32'd0);
        @(negedge clk);
        n_rst = 1'b1;
        wait_ready(n);
        chk("clear_cycles", 32'(n), 32'(NW));
        chk("idle_busy", 32'(busy), 32'd0);
        @(negedge clk);

        issue(1'b0, 32'h000, 32'h0, 3'd2, 1, 32'h0000_0000, 1'b0);

        issue(1'b1, 32'h004, 32'hDEAD_BEEF, 3'd2, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h007, 32'h0, 3'd0, 1, 32'hFFFF_FFDE, 1'b0);
        issue(1'b0, 32'h005, 32'h0, 3'd4, 1, 32'h0000_00BE, 1'b0);
        issue(1'b0, 32'h004, 32'h0, 3'd1, 1, 32'hFFFF_BEEF, 1'b0);
        issue(1'b0, 32'h006, 32'h0, 3'd5, 1, 32'h0000_DEAD, 1'b0);

        issue(1'b1, 32'h008, 32'h0, 3'd2, 1, 32'h0, 1'b0);
        issue(1'b1, 32'h009, 32'h1234_5678, 3'd0, 1, 32'h0, 1'b0);
        issue(1'b1, 32'h00A, 32'hAAAA_8001, 3'd1, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h008, 32'h0, 3'd2, 1, 32'h8001_7800, 1'b0);

        issue(1'b1, 32'h010, 32'h1122_3344, 3'd2, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h003, 32'h0, 3'd1, 1, 32'h0, 1'b1);
        issue(1'b1, 32'h012, 32'hFFFF_FFFF, 3'd2, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h010, 32'h0, 3'd2, 1, 32'h1122_3344, 1'b0);
        issue(1'b0, 32'h000, 32'h0, 3'd7, 1, 32'h0, 1'b1);
        issue(1'b1, 32'h000, 32'h0, 3'd3, 1, 32'h0, 1'b1);
        issue(1'b0, 32'h1000, 32'h0, 3'd2, 1, 32'h0, 1'b1);
        drain();

        // Back-to-back store / load / load through the 3-stage pipeline
        issue(1'b1, 32'h020, 32'hCAFE_F00D, 3'd2, 1, 32'h0, 1'b0);
        issue(1'b0, 32'h020, 32'h0, 3'd2, 1, 32'hCAFE_F00D, 1'b0);
        issue(1'b0, 32'h021, 32'h0, 3'd4, 1, 32'h0000_00F0, 1'b0);
        #1;
        chk("busy_inflight", 32'(busy), 32'd1);
        drain();

        // Random traffic against the byte model
        for (int k = 0; k < 400; k++) begin
            int          a;
            logic [31:0] wd;
            logic [2:0]  f3;
            logic        we;
            a  = ($urandom % 10 == 0) ? 4096 + int'($urandom % 4096) : int'($urandom % 64);
            wd = $urandom;
            f3 = 3'($urandom);
            we = 1'($urandom);
            issue(we, a, wd, f3, 0, 32'h0, 1'b0);
            repeat ($urandom % 3) @(negedge clk);
        end
        drain();

        // Reset with a load in flight: response must vanish, sweep restarts
        issue(1'b0, 32'h020, 32'h0, 3'd2, 0, 32'h0, 1'b0);
        n_rst = 1'b0;
        sbq.delete();
        model_clear();
        #1;
        chk("rst2_ready", 32'(bus.req_ready), 32'd0);
        chk("rst2_busy", 32'(busy), 32'd1);
        repeat (2) @(negedge clk);
        n_rst = 1'b1;
        wait_ready(n);
        chk("clear2_cycles", 32'(n), 32'(NW));
        @(negedge clk);
        issue(1'b0, 32'h020, 32'h0, 3'd2, 1, 32'h0000_0000, 1'b0);
        drain();
        repeat (4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/dmem_lsu_ctrl.md
Name: dmem_lsu_ctrl

Overview:
Parametrised byte-addressable RV32 data memory with a load/store unit front end. Replaces the single-cycle combinational-read data memory in the MEM stage.
- Valid/ready request handshake.
- Configurable read-pipeline latency.
- Offset-correct sub-word load extraction.
- Byte-enable stores.
- Misalignment, illegal-funct3 and out-of-range error reporting.
- Optional hardware clear sweep after reset.

Parameters:
NUM_WORDS, 1024, memory depth in 32-bit words; power of two.
ADDR_W, 12, byte-address width; must be at least log2(NUM_WORDS)+2.
READ_LAT, 1, cycles from request acceptance to response; legal range 1..4.
RESET_CLEAR, 1, 1 = sweep memory to zero after reset; 0 = memory contents are undefined after reset.

Ports:
clk  in  1  clock
n_rst  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, LSB-aligned
req_funct3  in  3  RV32 load/store funct3
rsp_valid  out  1  response strobe, one cycle per accepted request
rsp_rdata  out  32  load result (extended); 0 for stores and errors
rsp_err  out  1  request was rejected (no memory side effect)
busy  out  1  clear sweep in progress or a response is in flight

Behaviour:
- Reset: n_rst is asynchronous, active-low; clock is clk.
- Reset values: rsp_valid=0, rsp_rdata=0, rsp_err=0, pipeline cleared.
  - If RESET_CLEAR=1: state=CLEAR, req_ready=0, busy=1.
  - If RESET_CLEAR=0: state=RUN, req_ready=1.
- FSM states:
  - CLEAR: writes one zero word per cycle, index 0..NUM_WORDS-1. After the last index, goes to RUN.
  - RUN: req_ready=1.
  - No other states.
- Accept = req_valid & req_ready. One request per cycle; requests are fully pipelined; no response backpressure.
- Address decode: off=req_addr[1:0], widx=req_addr[ADDR_W-1:2].
- Error check, evaluated at accept:
  - Misaligned: halfword with off[0]=1; word with off!=0.
  - Illegal funct3: loads 3/6/7; stores >2.
  - Out of range: widx>=NUM_WORDS.
  - On error: no write; response has rsp_err=1, rsp_rdata=0.
- Store: write occurs on the accept edge.
  - Byte enables: sb = 1<<off; sh = 2'b11<<off; sw = 4'b1111.
  - Data: req_wdata replicated into byte lanes (sb: byte×4, sh: half×2).
  - Unselected bytes are untouched.
- Load: word sampled on the accept edge, delayed through READ_LAT-1 further stages.
  - Extraction: byte = word>>(8*off); half = word>>(8*off).
  - lb/lh sign-extend; lbu/lhu zero-extend; lw passes the word through.
- Latency: rsp_valid pulses exactly READ_LAT cycles after the accept edge, for loads and stores alike. Responses are returned in acceptance order.
- Hazards: a load accepted the cycle after a store to the same word returns the new data (the store committed on an earlier edge). No stale-read window.
- Idle cycles: pipeline stages with no accept carry rsp_valid=0. rsp_rdata/rsp_err are held at 0 when rsp_valid=0.
- Reset mid-operation: in-flight responses are discarded immediately. The clear sweep restarts from index 0 if RESET_CLEAR=1. Memory writes already committed persist if RESET_CLEAR=0.
- busy = (state==CLEAR) | any pipeline stage valid.

Optional Feature:
DMEM_PERF_CNT_EN
- Defined: adds outputs perf_loads, perf_stores, perf_errs (32 bits each).
  - Each increments on the accept of a successful load, a successful store, or an errored request, respectively.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Undefined: these ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
1. RESET_CLEAR=1, release n_rst → req_ready=0 for 1024 cycles, then 1; lw 0x000 → rsp_rdata=0x00000000, rsp_err=0.
2. sw 0x004 data 0xDEADBEEF, then loads → lb 0x007 = 0xFFFFFFDE; lbu 0x005 = 0x000000BE; lh 0x004 = 0xFFFFBEEF; lhu 0x006 = 0x0000DEAD.
3. sw 0x008 data 0; sb 0x009 data 0x12345678; sh 0x00A data 0xAAAA8001 → lw 0x008 = 0x80017800.
4. sw 0x010 data 0x11223344, then lh 0x003 → err; sw 0x012 data 0xFFFFFFFF → err; lw 0x010 = 0x11223344 (unchanged). funct3=7 load → err. Address 0x1000 with ADDR_W=13, NUM_WORDS=1024 → err.
5. READ_LAT=3: sw 0x020 data 0xCAFEF00D, lw 0x020, lbu 0x021 on 3 consecutive cycles → rsp_valid high cycles 3, 4, 5 after the first accept; responses 0 / 0xCAFEF00D / 0x000000F0, in order.
6. READ_LAT=2: assert n_rst one cycle after a load is accepted → rsp_valid stays 0, no response emerges; state returns to CLEAR.
